// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline types for the hazard controller:
// scoreboard entry, controller mode and register constants.
package pipe_hazard_ctrl_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } sb_entry_t;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_STALL = 2'd1,
        MODE_FLUSH = 2'd2
    } mode_e;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: REG_ZERO};

    function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] r);
        return e.valid && (e.rd == r);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with asynchronous active-high reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the forwarding-less 5-stage pipeline.
// Tracks in-flight destinations in EX/MEM/WB and sequences PC and IF/ID.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_rs_used_i,
    input  logic             id_rt_used_i,
    input  logic             id_reg_write_i,
    input  logic [4:0]       id_wr_reg_i,
    input  logic             br_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    sb_entry_t sb_ex_q, sb_mem_q, sb_wb_q;
    sb_entry_t sb_ex_d, sb_mem_d, sb_wb_d;
    sb_entry_t id_entry;
    logic      first_q;
    logic      rs_hz, rt_hz, hz;
    mode_e     mode;

    // WB is matched too: the regfile write lands at the edge ending WB.
    always_comb begin
        rs_hz = id_rs_used_i && (id_rs_i != REG_ZERO)
              && (sb_hit(sb_ex_q, id_rs_i) || sb_hit(sb_mem_q, id_rs_i)
                  || sb_hit(sb_wb_q, id_rs_i));
        rt_hz = id_rt_used_i && (id_rt_i != REG_ZERO)
              && (sb_hit(sb_ex_q, id_rt_i) || sb_hit(sb_mem_q, id_rt_i)
                  || sb_hit(sb_wb_q, id_rt_i));
        hz    = rs_hz || rt_hz;
    end

    // Reset and the first cycle after release always run.
    always_comb begin
        mode = MODE_RUN;
        if (!rst_i && !first_q) begin
            if (br_taken_i) begin
                mode = MODE_FLUSH;
            end else if (hz) begin
                mode = MODE_STALL;
            end
        end
    end

    always_comb begin
        id_entry.valid = id_reg_write_i && (id_wr_reg_i != REG_ZERO);
        id_entry.rd    = id_wr_reg_i;

        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        exmem_bubble_o = 1'b0;
        sb_ex_d        = id_entry;
        sb_mem_d       = sb_ex_q;
        sb_wb_d        = sb_mem_q;

        unique case (mode)
            MODE_FLUSH: begin
                ifid_flush_o   = 1'b1;
                idex_bubble_o  = 1'b1;
                exmem_bubble_o = 1'b1;
                sb_ex_d        = SB_EMPTY;
                sb_mem_d       = SB_EMPTY;
            end
            MODE_STALL: begin
                pc_write_o    = 1'b0;
                ifid_write_o  = 1'b0;
                idex_bubble_o = 1'b1;
                sb_ex_d       = SB_EMPTY;
            end
            MODE_RUN: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_ex_q  <= SB_EMPTY;
            sb_mem_q <= SB_EMPTY;
            sb_wb_q  <= SB_EMPTY;
            first_q  <= 1'b1;
        end else begin
            sb_ex_q  <= sb_ex_d;
            sb_mem_q <= sb_mem_d;
            sb_wb_q  <= sb_wb_d;
            first_q  <= 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (mode == MODE_STALL),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (mode == MODE_FLUSH),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipelined CPU, which has no forwarding paths. It keeps a 3-entry scoreboard of the destination registers in flight in the EX, MEM and WB stages. From that it stalls IF/ID when the instruction in ID reads a pending register, and it squashes wrong-path instructions when a branch resolves taken in MEM. It drives the PC write enable, the IF/ID write and flush, and the bubble inserts for ID/EX and EX/MEM, and keeps saturating stall and flush counters for debug.

## Interface
- CNT_W, 16, width of the stall and flush event counters
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- id_rs_i  in  5  rs field of the instruction in ID
- id_rt_i  in  5  rt field of the instruction in ID
- id_rs_used_i  in  1  instruction in ID reads rs
- id_rt_used_i  in  1  instruction in ID reads rt (R-type, beq, sw)
- id_reg_write_i  in  1  RegWrite from the decoder for the instruction in ID
- id_wr_reg_i  in  5  resolved destination of the instruction in ID (RegDst already applied)
- br_taken_i  in  1  Branch AND zero of the instruction in MEM
- pc_write_o  out  1  PC load enable
- ifid_write_o  out  1  IF/ID load enable
- ifid_flush_o  out  1  load IF/ID with an all-zero NOP
- idex_bubble_o  out  1  load ID/EX control fields with zeros
- exmem_bubble_o  out  1  load EX/MEM control fields with zeros
- stall_cnt_o  out  CNT_W  saturating count of stall cycles
- flush_cnt_o  out  CNT_W  saturating count of branch flushes

## Operation
- **Scoreboard.** Entries sb_ex, sb_mem, sb_wb, each {valid, reg[4:0]}. An entry is valid only if the instruction writes a nonzero register.
- **Hazard condition.** hz = (id_rs_used_i AND id_rs_i≠0 AND id_rs_i matches any valid entry) OR (the same test for rt). Register $0 never causes a hazard.
- **WB entry is included in the match.** The register file writes at the edge that ends WB, so a same-cycle read would return stale data.
- **Mode priority.** FLUSH over STALL over RUN. The mode is decoded combinationally each cycle.
- **FLUSH** (br_taken_i=1):
  - Outputs: pc_write_o=1 (PC takes the branch target), ifid_write_o=1, ifid_flush_o=1, idex_bubble_o=1, exmem_bubble_o=1.
  - Next scoreboard: sb_ex←invalid, sb_mem←invalid, sb_wb←sb_mem.
  - flush_cnt increments. hz is ignored and stall_cnt does not increment.
- **STALL** (br_taken_i=0, hz=1):
  - Outputs: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, other outputs 0.
  - Next scoreboard: sb_ex←invalid, sb_mem←sb_ex, sb_wb←sb_mem.
  - stall_cnt increments.
- **RUN:**
  - Outputs: pc_write_o=1, ifid_write_o=1, flush and bubble outputs 0.
  - Next scoreboard: sb_ex←{id_reg_write_i AND id_wr_reg_i≠0, id_wr_reg_i}, sb_mem←sb_ex, sb_wb←sb_mem.
- **Counters.** Saturate at 2^CNT_W−1 and never wrap.
- **Flushed NOP.** The all-zero NOP (sll $0) writes $0 only, so it never enters the scoreboard.

## Timing
- All outputs except the counters are combinational from the current inputs and the scoreboard. There is no added latency, because the stall or flush must act on the edge of the same cycle.
- The scoreboard and counters are registered and updated on the rising edge.
- Stall length for a consumer directly behind its producer is 3 cycles. With one independent instruction between them it is 2 cycles, and with two between it is 1 cycle.
- Reset (any time, including mid-stall or mid-flush): all entries invalid, counters 0.
  - Outputs while rst_i=1 and in the first cycle after release: pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_bubble_o=0, exmem_bubble_o=0.
  - No stall carries over past reset.
- br_taken_i asserted during a stall cycle: FLUSH applies in that cycle, and the stalled ID instruction is discarded by ifid_flush_o.

## Structure
- Shared pipeline package holds:
  - the scoreboard entry typedef {valid, reg[4:0]}
  - the mode encoding RUN/STALL/FLUSH
  - the constant REG_ZERO=5'd0
- One natural sub-module, sat_counter (parameter W; inputs inc and rst), instantiated twice for the stall and flush counters.

## Test plan
- **Back-to-back RAW.** addi $1,$0,5 then add $2,$1,$1 → pc_write_o=0 for exactly 3 consecutive cycles, idex_bubble_o=1 in each, stall_cnt_o=3. add then issues and $2=10.
- **One-instruction gap.** addi $1, an unrelated op, then add $2,$1,$1 → 2 stall cycles.
- **$0 dependency.** Stream of addi $0,$0,1 followed by add $3,$0,$0 → no stall, stall_cnt_o stays 0.
- **Branch taken vs pending stall.** beq taken in MEM while ID has a RAW hazard → FLUSH, not STALL:
  - in that cycle: ifid_flush_o=1, idex_bubble_o=1, exmem_bubble_o=1, pc_write_o=1
  - next cycle: sb_ex and sb_mem invalid
  - counts: flush_cnt_o=1, stall_cnt_o unchanged.
- **Reset mid-stall.** Assert rst_i in the second stall cycle, asynchronously mid-cycle → outputs go to reset values immediately. After release: scoreboard empty and counters 0.
- **Counter saturation.** CNT_W=4 with 20 stall cycles → stall_cnt_o holds 15 and does not wrap.
